// File: rtl/unpack_metadata_pkg.sv
// Shared packer/unpacker constants: chunk geometry, clog2, FSM encoding.
package unpack_metadata_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_PASS    = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    COLLECT = ST_COLLECT,
    PASS    = ST_PASS
  } state_t;

  function automatic int calc_pw(input int dw, input int du);
    return dw - du;
  endfunction

  function automatic int calc_nchunk(input int dw, input int du,
                                     input int mw);
    return mw / (dw - du);
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/unpack_metadata_if.sv
// Sample/metadata bundle between the sample source and the unpacker.
interface unpack_metadata_if #(
  parameter int data_width      = 16,
  parameter int meta_data_width = 464
);
  logic                       enable;
  logic                       init;
  logic [data_width-1:0]      data_in;
  logic                       strobe_in;
  logic [data_width-1:0]      data_out;
  logic                       strobe_out;
  logic [meta_data_width-1:0] meta_data;
  logic                       meta_valid;
  logic                       meta_abort;
  logic                       busy;

  modport master (
    output enable, init, data_in, strobe_in,
    input  data_out, strobe_out, meta_data,
    input  meta_valid, meta_abort, busy
  );

  modport slave (
    input  enable, init, data_in, strobe_in,
    output data_out, strobe_out, meta_data,
    output meta_valid, meta_abort, busy
  );
endinterface

// File: rtl/unpack_metadata_shifter.sv
// Chunk shift register and counter; chunk 0 ends up in the low bits.
module meta_chunk_shifter
  import unpack_metadata_pkg::*;
#(
  parameter int PW     = 4,
  parameter int NCHUNK = 4,
  parameter int MW     = 16,
  parameter int CW     = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          shift_en,
  input  logic [PW-1:0] chunk,
  output logic [MW-1:0] shift_nxt,
  output logic [CW-1:0] count,
  output logic          done
);

  logic [MW-1:0] shift_q;
  logic [CW-1:0] count_q;

  if (NCHUNK == 1) begin : g_one
    assign shift_nxt = chunk;
  end else begin : g_many
    assign shift_nxt = {chunk, shift_q[MW-1:PW]};
  end

  assign count = count_q;
  assign done  = shift_en && (count_q == CW'(NCHUNK-1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      count_q <= '0;
    end else if (clear) begin
      shift_q <= '0;
      count_q <= '0;
    end else if (shift_en) begin
      shift_q <= shift_nxt;
      count_q <= done ? '0 : count_q + 1'b1;
    end
  end

endmodule

// File: rtl/unpack_metadata.sv
// Strips metadata chunks off sample high bits and reassembles the word.
// Optional: UNPACK_SIGN_EXTEND_EN sign-extends the stripped samples.
module unpack_metadata
  import unpack_metadata_pkg::*;
#(
  parameter int data_width      = 16,
  parameter int data_width_used = 12,
  parameter int meta_data_width = 464
) (
  input logic              clock,
  input logic              reset,
  unpack_metadata_if.slave bus
);

  localparam int PW     = calc_pw(data_width, data_width_used);
  localparam int NCHUNK = calc_nchunk(data_width, data_width_used,
                                      meta_data_width);
  localparam int CW     = clog2(NCHUNK + 1);
  localparam int DW     = data_width;
  localparam int DU     = data_width_used;
  localparam int MW     = meta_data_width;

  if (DU >= DW) begin : g_bad_used
    $error("data_width_used must be < data_width");
  end
  if (MW % PW != 0) begin : g_bad_meta
    $error("meta_data_width must be a multiple of the chunk width");
  end

  state_t          state_q, state_d;
  logic            acc, collecting, done;
  logic [CW-1:0]   count;
  logic [MW-1:0]   shift_nxt;
  logic [DW-1:0]   stripped;
  logic [DW-1:0]   dout_q, dout_d;
  logic [MW-1:0]   meta_q, meta_d;
  logic            strb_q, strb_d;
  logic            mv_q, mv_d;
  logic            ma_q, ma_d;

  assign acc        = bus.enable & bus.strobe_in & ~bus.init;
  assign collecting = (state_q == COLLECT);

`ifdef UNPACK_SIGN_EXTEND_EN
  assign stripped = {{PW{bus.data_in[DU-1]}}, bus.data_in[DU-1:0]};
`else
  assign stripped = {{PW{1'b0}}, bus.data_in[DU-1:0]};
`endif

  meta_chunk_shifter #(
    .PW     (PW),
    .NCHUNK (NCHUNK),
    .MW     (MW),
    .CW     (CW)
  ) u_shifter (
    .clock     (clock),
    .reset     (reset),
    .clear     (bus.init),
    .shift_en  (acc & collecting),
    .chunk     (bus.data_in[DW-1:DU]),
    .shift_nxt (shift_nxt),
    .count     (count),
    .done      (done)
  );

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    meta_d  = meta_q;
    strb_d  = 1'b0;
    mv_d    = 1'b0;
    ma_d    = 1'b0;
    unique case (1'b1)
      bus.init: begin
        state_d = COLLECT;
        ma_d    = collecting && (count != '0);
      end
      acc: begin
        dout_d = stripped;
        strb_d = 1'b1;
        if (done) begin
          meta_d  = shift_nxt;
          mv_d    = 1'b1;
          state_d = PASS;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dout_q  <= '0;
      meta_q  <= '0;
      strb_q  <= 1'b0;
      mv_q    <= 1'b0;
      ma_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      meta_q  <= meta_d;
      strb_q  <= strb_d;
      mv_q    <= mv_d;
      ma_q    <= ma_d;
    end
  end

  assign bus.data_out   = dout_q;
  assign bus.strobe_out = strb_q;
  assign bus.meta_data  = meta_q;
  assign bus.meta_valid = mv_q;
  assign bus.meta_abort = ma_q;
  assign bus.busy       = collecting;

endmodule

// File: tb/tb_unpack_metadata.sv
// Directed bench for unpack_metadata at 16/12/16 (four 4-bit chunks).
module tb_unpack_metadata;

  localparam int DW = 16;
  localparam int DU = 12;
  localparam int MW = 16;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  unpack_metadata_if #(.data_width(DW), .meta_data_width(MW)) bus ();

  unpack_metadata #(
    .data_width      (DW),
    .data_width_used (DU),
    .meta_data_width (MW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] exp_out(input logic [15:0] d);
`ifdef UNPACK_SIGN_EXTEND_EN
    return {{4{d[11]}}, d[11:0]};
`else
    return {4'h0, d[11:0]};
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en, input logic ini,
                      input logic stb, input logic [15:0] d);
    bus.enable    = en;
    bus.init      = ini;
    bus.strobe_in = stb;
    bus.data_in   = d;
    @(posedge clock);
    #1;
  endtask

  task automatic sample(input logic [15:0] d, input logic mv,
                        input string tag);
    step(1'b1, 1'b0, 1'b1, d);
    chk({tag, ".data"}, 64'(bus.data_out), 64'(exp_out(d)));
    chk({tag, ".strb"}, 64'(bus.strobe_out), 64'd1);
    chk({tag, ".mv"}, 64'(bus.meta_valid), 64'(mv));
  endtask

  task automatic do_reset;
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    reset = 1'b0;
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".data"}, 64'(bus.data_out), 64'd0);
    chk({tag, ".strb"}, 64'(bus.strobe_out), 64'd0);
    chk({tag, ".meta"}, 64'(bus.meta_data), 64'd0);
    chk({tag, ".mv"}, 64'(bus.meta_valid), 64'd0);
    chk({tag, ".ma"}, 64'(bus.meta_abort), 64'd0);
    chk({tag, ".busy"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b0;
    bus.enable = 1'b0;
    bus.init = 1'b0;
    bus.strobe_in = 1'b0;
    bus.data_in = '0;

    do_reset();
    chk_zero("rst");

    // 1: basic frame
    step(1'b1, 1'b1, 1'b0, 16'h0);
    chk("t1.busy_init", 64'(bus.busy), 64'd1);
    chk("t1.strb_init", 64'(bus.strobe_out), 64'd0);
    sample(16'h1ABC, 1'b0, "t1.s0");
    sample(16'h2DEF, 1'b0, "t1.s1");
    sample(16'h3123, 1'b0, "t1.s2");
    chk("t1.busy_mid", 64'(bus.busy), 64'd1);
    chk("t1.meta_mid", 64'(bus.meta_data), 64'd0);
    sample(16'h4456, 1'b1, "t1.s3");
    chk("t1.meta", 64'(bus.meta_data), 64'h4321);
    chk("t1.busy_done", 64'(bus.busy), 64'd0);
    sample(16'h5789, 1'b0, "t1.s4");
    chk("t1.meta_hold", 64'(bus.meta_data), 64'h4321);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    chk("t1.idle_strb", 64'(bus.strobe_out), 64'd0);
    chk("t1.idle_data", 64'(bus.data_out), 64'(exp_out(16'h5789)));

    // 2: abort then clean frame
    do_reset();
    step(1'b1, 1'b1, 1'b0, 16'h0);
    sample(16'h1000, 1'b0, "t2.a0");
    sample(16'h2000, 1'b0, "t2.a1");
    step(1'b1, 1'b1, 1'b0, 16'h0);
    chk("t2.abort", 64'(bus.meta_abort), 64'd1);
    chk("t2.abort_meta", 64'(bus.meta_data), 64'd0);
    sample(16'hA000, 1'b0, "t2.b0");
    chk("t2.abort_once", 64'(bus.meta_abort), 64'd0);
    sample(16'hB000, 1'b0, "t2.b1");
    sample(16'hC000, 1'b0, "t2.b2");
    chk("t2.meta_pre", 64'(bus.meta_data), 64'd0);
    sample(16'hD000, 1'b1, "t2.b3");
    chk("t2.meta", 64'(bus.meta_data), 64'hDCBA);
    chk("t2.no_abort", 64'(bus.meta_abort), 64'd0);

    // 3: init with coincident strobe, from PASS (no abort)
    step(1'b1, 1'b1, 1'b1, 16'h7FFF);
    chk("t3.strb", 64'(bus.strobe_out), 64'd0);
    chk("t3.ma", 64'(bus.meta_abort), 64'd0);
    sample(16'h1001, 1'b0, "t3.s0");
    sample(16'h2002, 1'b0, "t3.s1");
    sample(16'h3003, 1'b0, "t3.s2");
    sample(16'h4004, 1'b1, "t3.s3");
    chk("t3.meta", 64'(bus.meta_data), 64'h4321);

    // 4: enable gap between chunks 1 and 2
    step(1'b1, 1'b1, 1'b0, 16'h0);
    sample(16'h5000, 1'b0, "t4.s0");
    sample(16'h6000, 1'b0, "t4.s1");
    step(1'b0, 1'b0, 1'b1, 16'hF000);
    chk("t4.gap0", 64'(bus.strobe_out), 64'd0);
    step(1'b0, 1'b0, 1'b0, 16'hF000);
    chk("t4.gap1", 64'(bus.strobe_out), 64'd0);
    step(1'b0, 1'b0, 1'b1, 16'hF000);
    chk("t4.gap2", 64'(bus.strobe_out), 64'd0);
    chk("t4.gap_busy", 64'(bus.busy), 64'd1);
    sample(16'h7000, 1'b0, "t4.s2");
    sample(16'h8000, 1'b1, "t4.s3");
    chk("t4.meta", 64'(bus.meta_data), 64'h8765);

    // 5: async reset mid-collect
    step(1'b1, 1'b1, 1'b0, 16'h0);
    sample(16'h1111, 1'b0, "t5.s0");
    sample(16'h2222, 1'b0, "t5.s1");
    #2;
    reset = 1'b1;
    #1;
    chk_zero("t5.rst");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample(16'h9555, 1'b0, "t5.idle");
      chk("t5.meta", 64'(bus.meta_data), 64'd0);
      chk("t5.busy", 64'(bus.busy), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
